instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  field set presented.
REQ-004 SHALL have ports: in_ready  output  1  high when the block can accept a field set.
REQ-005 SHALL have ports: opcode  input  7, rd/rs1/rs2  input  5 each, funct3  input  3, funct7  input  7, imm  input  32  RV32I fields to encode.
REQ-006 SHALL have ports: out_valid  output  1, out_ready  input  1  encoded-word handshake.
REQ-007 SHALL have ports: out_instr  output  32  encoded instruction, out_addr  output  32  byte address of out_instr.
REQ-008 SHALL have ports: err  output  1  one-cycle pulse on rejected input; fill_count  output  3  FIFO occupancy 0..4.

Function
REQ-009 SHALL accept input on a cycle where in_valid && in_ready; in_ready = (fill_count < 4), independent of out_ready.
REQ-010 SHALL encode in one cycle and write the word into a 4-entry FIFO; word accepted at edge N is visible on out_instr with out_valid after edge N (latency 1 when empty, no combinational bypass).
REQ-011 SHALL encode R (0110011): funct7|rs2|rs1|funct3|rd|opcode.
REQ-012 SHALL encode I (0000011, 1100111, 0010011): imm[11:0]|rs1|funct3|rd|opcode; for 0010011 with funct3 001/101, bits[31:25]=funct7, bits[24:20]=imm[4:0].
REQ-013 SHALL encode S (0100011): imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
REQ-014 SHALL encode B (1100011): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
REQ-015 SHALL encode U (0110111, 0010111): imm[31:12]|rd|opcode; J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-016 SHALL reject (no FIFO write, err=1 next cycle for one cycle) any opcode outside REQ-011..015, or B/J with imm[0]=1; rejected input still counts as accepted handshake.
REQ-017 SHALL pop on out_valid && out_ready; out_valid = (fill_count > 0).
REQ-018 SHALL allow simultaneous push and pop when 0<fill_count<4: count unchanged, order preserved.
REQ-019 SHALL wrap FIFO read/write pointers modulo 4.
REQ-020 SHALL advance out_addr by 4 on each pop, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-021 SHALL hold out_instr/out_addr stable while out_valid && !out_ready.

Reset
REQ-022 SHALL on reset: fill_count=0, pointers=0, out_valid=0, out_instr=0, out_addr=0, err=0, in_ready=1 next cycle.
REQ-023 SHALL let reset override any same-cycle push/pop; buffered words discarded.

Structure
REQ-024 SHALL take the opcode constants (shared with the decode unit) and FIFO depth from the shared RV32I package.
REQ-025 SHALL isolate the 4-entry FIFO as sub-module instr_fifo; encoding is combinational logic in the top.

Verification
REQ-026 SHALL check addi x1,x0,5 (op 0010011, f3 000, imm 5) -> 0x00500093 at out_addr 0x0.
REQ-027 SHALL check add x3,x1,x2 -> 0x002081B3; sw x2,8(x1) -> 0x0020A423; lui x5,imm 0x12345000 -> 0x123452B7.
REQ-028 SHALL check beq x1,x2,+8 -> 0x00208463; jal x1,+16 -> 0x010000EF; jal with imm=17 -> err pulse, no word.
REQ-029 SHALL check out_ready=0 with 5 pushes -> 4 stored, in_ready=0, fifth held; release -> 4 words in order, addrs 0x0,0x4,0x8,0xC.
REQ-030 SHALL check opcode 0x7F -> err=1 one cycle, fill_count unchanged; reset with 3 buffered -> fill_count=0, out_valid=0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - shared RV32I opcode constants, format classification and FIFO depth
package instr_encoder_pkg;

   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = PTR_W + 1;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_e;

   function automatic fmt_e fmt_of(input logic [6:0] op);
      case (op)
         OP_REG:                   return FMT_R;
         OP_LOAD, OP_JALR, OP_IMM: return FMT_I;
         OP_STORE:                 return FMT_S;
         OP_BRANCH:                return FMT_B;
         OP_LUI, OP_AUIPC:         return FMT_U;
         OP_JAL:                   return FMT_J;
         default:                  return FMT_BAD;
      endcase
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - 4-entry word FIFO with wrapping pointers and occupancy count
module instr_fifo
   import instr_encoder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [31:0]      i_data,
   input  logic             i_pop,
   output logic [31:0]      o_data,
   output logic [CNT_W-1:0] o_count
);

   logic [31:0]      r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (i_push && !reset) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers are exactly log2(depth) wide so they wrap without explicit compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = (r_count != '0) ? r_mem[r_rd_ptr] : 32'h0;
   assign o_count = r_count;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-to-word encoder feeding an addressed output FIFO
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        err,
   output logic [2:0]  fill_count
);

   fmt_e             w_fmt;
   logic [31:0]      w_word;
   logic             w_reject;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count;
   logic             r_err;
   logic [31:0]      r_addr;

   always_comb begin
      w_fmt    = fmt_of(opcode);
      w_word   = 32'h0;
      w_reject = 1'b0;
      case (w_fmt)
         FMT_R: w_word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            // Shift-immediates carry funct7 in the upper immediate bits.
            if (opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101))
               w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            else
               w_word = {imm[11:0], rs1, funct3, rd, opcode};
         end
         FMT_S: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B: begin
            w_word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            w_reject = imm[0];
         end
         FMT_U: w_word = {imm[31:12], rd, opcode};
         FMT_J: begin
            w_word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            w_reject = imm[0];
         end
         default: w_reject = 1'b1;
      endcase
   end

   assign in_ready  = (w_count < CNT_W'(FIFO_DEPTH));
   assign out_valid = (w_count != '0);
   assign w_accept  = in_valid && in_ready;
   assign w_push    = w_accept && !w_reject;
   assign w_pop     = out_valid && out_ready;

   instr_fifo u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_word),
      .i_pop   (w_pop),
      .o_data  (out_instr),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_err  <= 1'b0;
         r_addr <= 32'h0;
      end else begin
         r_err <= w_accept && w_reject;
         if (w_pop) r_addr <= r_addr + 32'd4;
      end
   end

   assign err        = r_err;
   assign out_addr   = r_addr;
   assign fill_count = w_count;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed self-checking bench for instr_encoder
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        err;
   logic [2:0]  fill_count;

   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] m_q[$];
   logic [31:0] m_addr;
   logic        m_err;

   instr_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .opcode     (opcode),
      .rd         (rd),
      .rs1        (rs1),
      .rs2        (rs2),
      .funct3     (funct3),
      .funct7     (funct7),
      .imm        (imm),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_addr   (out_addr),
      .err        (err),
      .fill_count (fill_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic void ref_encode(
      input  logic [6:0]  op,
      input  logic [4:0]  f_rd,
      input  logic [4:0]  f_rs1,
      input  logic [4:0]  f_rs2,
      input  logic [2:0]  f3,
      input  logic [6:0]  f7,
      input  logic [31:0] im,
      output logic [31:0] w,
      output bit          bad
   );
      logic [31:0] o, d, s1, s2, t3, t7;
      o   = 32'(op);
      d   = 32'(f_rd) << 7;
      s1  = 32'(f_rs1) << 15;
      s2  = 32'(f_rs2) << 20;
      t3  = 32'(f3) << 12;
      t7  = 32'(f7) << 25;
      w   = 32'h0;
      bad = 1'b0;
      case (op)
         7'h33: w = t7 | s2 | s1 | t3 | d | o;
         7'h03, 7'h67: w = ((im & 32'hFFF) << 20) | s1 | t3 | d | o;
         7'h13: begin
            if (f3 == 3'd1 || f3 == 3'd5) w = t7 | ((im & 32'h1F) << 20) | s1 | t3 | d | o;
            else                          w = ((im & 32'hFFF) << 20) | s1 | t3 | d | o;
         end
         7'h23: w = (((im >> 5) & 32'h7F) << 25) | s2 | s1 | t3 | ((im & 32'h1F) << 7) | o;
         7'h63: begin
            w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | s2 | s1 | t3
              | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | o;
            bad = im[0];
         end
         7'h37, 7'h17: w = (im & 32'hFFFFF000) | d | o;
         7'h6F: begin
            w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
              | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | d | o;
            bad = im[0];
         end
         default: bad = 1'b1;
      endcase
   endfunction

   // One clock: predict, advance the model across the edge, then compare all outputs.
   task automatic tick();
      logic [31:0] w;
      bit          bad, acc, pop;
      acc = in_valid && (m_q.size() < 4);
      pop = out_ready && (m_q.size() > 0);
      ref_encode(opcode, rd, rs1, rs2, funct3, funct7, imm, w, bad);
      @(posedge clk);
      if (reset) begin
         m_q.delete();
         m_addr = 32'h0;
         m_err  = 1'b0;
      end else begin
         if (pop) begin
            void'(m_q.pop_front());
            m_addr = m_addr + 32'd4;
         end
         if (acc && !bad) m_q.push_back(w);
         m_err = acc && bad;
      end
      #1;
      check("fill_count", 32'(fill_count), 32'(m_q.size()));
      check("in_ready",   32'(in_ready),   32'(m_q.size() < 4));
      check("out_valid",  32'(out_valid),  32'(m_q.size() > 0));
      check("err",        32'(err),        32'(m_err));
      check("out_addr",   out_addr,        m_addr);
      check("out_instr",  out_instr,       (m_q.size() > 0) ? m_q[0] : 32'h0);
   endtask

   task automatic set_in(input logic v, input logic [6:0] op, input logic [4:0] f_rd,
                         input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
      in_valid = v;
      opcode   = op;
      rd       = f_rd;
      rs1      = f_rs1;
      rs2      = f_rs2;
      funct3   = f3;
      funct7   = f7;
      imm      = im;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic push_expect(input string tag, input logic [31:0] exp);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check(tag, out_instr, exp);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [6:0] valid_ops [9] = '{7'h33, 7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

   initial begin
      m_addr    = 32'h0;
      m_err     = 1'b0;
      out_ready = 1'b0;
      set_in(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
      reset = 1'b1;
      tick();
      do_reset();
      check("reset_fill", 32'(fill_count), 32'd0);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      set_in(1'b1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      check("addi_word", out_instr, 32'h00500093);
      check("addi_addr", out_addr, 32'h0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      set_in(1'b1, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
      push_expect("add_word", 32'h002081B3);
      set_in(1'b1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      push_expect("sw_word", 32'h0020A423);
      set_in(1'b1, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
      push_expect("lui_word", 32'h123452B7);
      set_in(1'b1, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      push_expect("beq_word", 32'h00208463);
      set_in(1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16);
      push_expect("jal_word", 32'h010000EF);

      set_in(1'b1, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd17);
      tick();
      in_valid = 1'b0;
      check("jal_odd_err", 32'(err), 32'd1);
      check("jal_odd_fill", 32'(fill_count), 32'd0);
      tick();
      check("jal_odd_err_clear", 32'(err), 32'd0);

      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 7'h33, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 32'h0);
         tick();
      end
      check("full_fill", 32'(fill_count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_addr", out_addr, 32'(4 * i));
         check("drain_word", out_instr, 32'h00208033 | (32'(i + 1) << 7));
         tick();
      end
      check("drain_empty", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i) << 12);
         tick();
      end
      set_in(1'b1, 7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0);
      tick();
      in_valid = 1'b0;
      check("badop_err", 32'(err), 32'd1);
      check("badop_fill", 32'(fill_count), 32'd3);
      tick();
      check("badop_err_clear", 32'(err), 32'd0);
      reset = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      reset = 1'b0;
      in_valid = 1'b0;
      check("rst3_fill", 32'(fill_count), 32'd0);
      check("rst3_out_valid", 32'(out_valid), 32'd0);

      for (int c = 0; c < 600; c++) begin
         logic [6:0] op;
         logic [31:0] im;
         op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : valid_ops[$urandom_range(0, 8)];
         im = $urandom;
         if ((op == 7'h63 || op == 7'h6F) && $urandom_range(0, 3) != 0) im[0] = 1'b0;
         set_in(1'($urandom_range(0, 2) != 0), op, 5'($urandom), 5'($urandom), 5'($urandom),
                3'($urandom), 7'($urandom), im);
         out_ready = 1'($urandom_range(0, 2) == 0);
         reset     = ($urandom_range(0, 79) == 0);
         tick();
         reset = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
